// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage immediate extender and branch-target generator
// for the ID->EX path. Stage 1 registers the extended immediate together
// with PC+4 and the tag. Stage 2 registers the branch target
// (PC+4 + ext) and drives every out_* port straight from its flops.
// A valid/ready handshake provides back-pressure, and flush drops all
// in-flight beats.
module imm_ext_pipe #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_imm,
    input  logic [1:0]         in_mode,
    input  logic [OUT_W-1:0]   in_pc4,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_ext,
    output logic [OUT_W-1:0]   out_target,
    output logic [TAG_W-1:0]   out_tag
);

    // Branch mode keeps the shifted immediate intact inside OUT_W, so the
    // widths must leave room for it.
    if (OUT_W < IN_W + BR_SHIFT) begin : g_width_check
        $error("imm_ext_pipe: OUT_W must be >= IN_W + BR_SHIFT");
    end

    // The extension is written with shifts rather than replications. This
    // keeps it legal when a replication count would be zero.
    function automatic logic [OUT_W-1:0] ext_fn(
        input logic [IN_W-1:0] imm,
        input logic [1:0]      mode
    );
        logic [OUT_W-1:0] zext_v;
        logic [OUT_W-1:0] sext_v;
        logic [OUT_W-1:0] res_v;
        zext_v = OUT_W'(imm);
        sext_v = zext_v | ({OUT_W{imm[IN_W-1]}} << IN_W);
        case (mode)
            2'b00:   res_v = zext_v;
            2'b01:   res_v = sext_v;
            2'b10:   res_v = sext_v << BR_SHIFT;
            2'b11:   res_v = zext_v << (OUT_W - IN_W);
            default: res_v = zext_v;
        endcase
        return res_v;
    endfunction

    logic               s1_valid_r;
    logic [OUT_W-1:0]   s1_ext_r;
    logic [OUT_W-1:0]   s1_pc4_r;
    logic [TAG_W-1:0]   s1_tag_r;
    logic               s2_valid_r;
    logic [OUT_W-1:0]   s2_ext_r;
    logic [OUT_W-1:0]   s2_target_r;
    logic [TAG_W-1:0]   s2_tag_r;

    logic               s2_adv_s;
    logic               s1_adv_s;
    logic               accept_s;

    // Each stage may move when the stage ahead of it is empty or is being
    // drained. in_ready therefore depends only on out_ready and the valid
    // bits, never on in_valid.
    always_comb begin
        s2_adv_s = ~s2_valid_r | out_ready;
        s1_adv_s = ~s1_valid_r | s2_adv_s;
        accept_s = in_valid & s1_adv_s & ~flush;
    end

    assign in_ready = s1_adv_s;

    // Stage 1 captures the extended immediate, PC+4 and tag of each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_ext_r   <= '0;
            s1_pc4_r   <= '0;
            s1_tag_r   <= '0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_ext_r <= ext_fn(in_imm, in_mode);
                s1_pc4_r <= in_pc4;
                s1_tag_r <= in_tag;
            end else begin
                s1_ext_r <= s1_ext_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2 forms the wrapping branch target and holds the beat until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r  <= 1'b0;
            s2_ext_r    <= '0;
            s2_target_r <= '0;
            s2_tag_r    <= '0;
        end else if (flush) begin
            s2_valid_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_ext_r    <= s1_ext_r;
                s2_target_r <= s1_pc4_r + s1_ext_r;
                s2_tag_r    <= s1_tag_r;
            end else begin
                s2_ext_r <= s2_ext_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign out_valid  = s2_valid_r;
    assign out_ext    = s2_ext_r;
    assign out_target = s2_target_r;
    assign out_tag    = s2_tag_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: a table of directed vectors,
// hand-written back-pressure / flush / reset sequences and a randomized
// stream checked against an arithmetic reference model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [31:0] in_pc4;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ext;
    logic [31:0] out_target;
    logic [4:0]  out_tag;

    int errors = 0;
    int checks = 0;

    imm_ext_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_pc4(in_pc4), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ext(out_ext), .out_target(out_target), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] imm;
        logic [1:0]  mode;
        logic [31:0] pc4;
        logic [4:0]  tag;
        logic [31:0] ext;
        logic [31:0] tgt;
    } vec_t;

    typedef struct {
        logic [31:0] ext;
        logic [31:0] tgt;
        logic [4:0]  tag;
    } beat_t;

    vec_t  vecs [7];
    beat_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: take the immediate's numeric value, then scale it arithmetically.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        longint sval;
        longint r;
        sval = longint'(imm);
        if (imm >= 16'h8000) sval = sval - 65536;
        case (mode)
            2'd0:    r = longint'(imm);
            2'd1:    r = sval;
            2'd2:    r = sval * 4;
            default: r = longint'(imm) * 65536;
        endcase
        return r[31:0];
    endfunction

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [31:0] pc4, input logic [4:0] tag);
        in_valid = v; in_imm = imm; in_mode = mode; in_pc4 = pc4; in_tag = tag;
    endtask

    initial begin
        logic [31:0] hold_ext;
        logic        flushed_ok;
        int          got;
        int          nxt;
        int          sent;
        logic        acc;
        logic        pv, pr;
        logic [31:0] pe, pt;
        logic [4:0]  ptag;
        beat_t       b;

        vecs[0] = '{16'h8004, 2'd0, 32'h0040_0010, 5'd1, 32'h0000_8004, 32'h0040_8014};
        vecs[1] = '{16'h8004, 2'd1, 32'h0040_0010, 5'd2, 32'hFFFF_8004, 32'h003F_8014};
        vecs[2] = '{16'h8004, 2'd2, 32'h0040_0010, 5'd3, 32'hFFFE_0010, 32'h003E_0020};
        vecs[3] = '{16'h8004, 2'd3, 32'h0040_0010, 5'd4, 32'h8004_0000, 32'h8044_0010};
        vecs[4] = '{16'h0002, 2'd2, 32'hFFFF_FFFC, 5'd5, 32'h0000_0008, 32'h0000_0004};
        vecs[5] = '{16'h7FFF, 2'd1, 32'h0000_0000, 5'd6, 32'h0000_7FFF, 32'h0000_7FFF};
        vecs[6] = '{16'hFFFF, 2'd2, 32'h0000_0100, 5'd7, 32'hFFFF_FFFC, 32'h0000_00FC};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0, 2'd0, 32'h0, 5'd0);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_ext", out_ext, 32'd0);
        chk("reset_out_target", out_target, 32'd0);
        chk("reset_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        #1 chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: visible exactly two edges after being presented.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].imm, vecs[i].mode, vecs[i].pc4, vecs[i].tag);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_not_early", i), 32'(out_valid), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_ext", i), out_ext, vecs[i].ext);
            chk($sformatf("vec%0d_target", i), out_target, vecs[i].tgt);
            chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(vecs[i].tag));
        end
        @(negedge clk);

        // Back-pressure: four beats, downstream stalled for the first cycles.
        got = 0; nxt = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready = (c >= 6);
            drive(nxt <= 4, 16'(nxt), 2'd0, 32'h0000_1000, 5'(nxt));
            #1;
            if (c >= 3 && c <= 5) begin
                chk("bp_in_ready_low", 32'(in_ready), 32'd0);
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_tag", 32'(out_tag), 32'd1);
                chk("bp_hold_ext", out_ext, 32'd1);
            end
            if (out_valid && out_ready) begin
                got++;
                chk("bp_order_tag", 32'(out_tag), 32'(got));
                chk("bp_ext", out_ext, 32'(got));
                chk("bp_target", out_target, 32'h0000_1000 + 32'(got));
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        chk("bp_delivered_count", 32'(got), 32'd4);

        // Flush with two beats in flight and a third presented.
        @(negedge clk); out_ready = 1'b1;
        drive(1'b1, 16'h0011, 2'd0, 32'h0, 5'd11);
        @(negedge clk); drive(1'b1, 16'h0012, 2'd0, 32'h0, 5'd12);
        @(negedge clk); drive(1'b1, 16'h0013, 2'd0, 32'h0, 5'd13); flush = 1'b1;
        #1 chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); flush = 1'b0; in_valid = 1'b0;
        chk("flush_next_valid", 32'(out_valid), 32'd0);
        flushed_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (out_valid) flushed_ok = 1'b0;
        end
        chk("flush_nothing_emerges", 32'(flushed_ok), 32'd1);

        // Asynchronous reset in the middle of a stalled beat.
        @(negedge clk); out_ready = 1'b0;
        drive(1'b1, 16'h1234, 2'd0, 32'h0000_0100, 5'd9);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ext", out_ext, 32'd0);
        chk("mid_rst_target", out_target, 32'd0);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        drive(1'b1, 16'h0042, 2'd1, 32'h0000_0200, 5'd3);
        #1 chk("mid_release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("mid_first_accept_valid", 32'(out_valid), 32'd1);
        chk("mid_first_accept_target", out_target, 32'h0000_0242);

        // Randomized stream against the reference model.
        @(negedge clk);
        sent = 0; pv = 1'b0; pr = 1'b1; pe = '0; pt = '0; ptag = '0;
        exp_q.delete();
        for (int c = 0; c < 2000 && (sent < 100 || exp_q.size() > 0); c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            drive((sent < 100) && ($urandom_range(0, 4) != 0), 16'($urandom),
                  2'($urandom_range(0, 3)), $urandom, 5'($urandom));
            #1;
            if (pv && !pr) begin
                chk("rnd_stall_valid", 32'(out_valid), 32'd1);
                chk("rnd_stall_ext", out_ext, pe);
                chk("rnd_stall_target", out_target, pt);
                chk("rnd_stall_tag", 32'(out_tag), 32'(ptag));
            end
            if (out_ready) chk("rnd_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_unexpected_beat", 32'(out_valid), 32'd0);
                end else begin
                    b = exp_q[0];
                    chk("rnd_ext", out_ext, b.ext);
                    chk("rnd_target", out_target, b.tgt);
                    chk("rnd_tag", 32'(out_tag), 32'(b.tag));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                b.ext = ref_ext(in_imm, in_mode);
                b.tgt = in_pc4 + b.ext;
                b.tag = in_tag;
                exp_q.push_back(b);
                sent++;
            end
            pv = out_valid; pr = out_ready; pe = out_ext; pt = out_target; ptag = out_tag;
        end
        in_valid = 1'b0;
        chk("rnd_all_sent", 32'(sent), 32'd100);
        chk("rnd_all_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
